// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction decode stage: field positions, class order,
// write-back class mask and FSM encoding.
package id_pkg;

  localparam int unsigned OpcHi      = 31;
  localparam int unsigned OpcLo      = 26;
  localparam int unsigned RdHi       = 25;
  localparam int unsigned RdLo       = 22;
  localparam int unsigned RsHi       = 21;
  localparam int unsigned RsLo       = 18;
  localparam int unsigned CcHi       = 17;
  localparam int unsigned CcLo       = 14;
  localparam int unsigned ImmFlagBit = 13;
  localparam int unsigned ImmHi      = 12;
  localparam int unsigned ImmW       = 13;

  localparam int unsigned NumClasses = 12;

  // Class index order; index i lights dopc bit (NumClasses-1-i).
  typedef enum logic [3:0] {
    ClsAddsub = 4'd0,
    ClsMul    = 4'd1,
    ClsDiv    = 4'd2,
    ClsAbs    = 4'd3,
    ClsShift  = 4'd4,
    ClsLogic  = 4'd5,
    ClsSet    = 4'd6,
    ClsLoad   = 4'd7,
    ClsStore  = 4'd8,
    ClsJump   = 4'd9,
    ClsNop    = 4'd10,
    ClsHalt   = 4'd11
  } cls_e;

  localparam logic [NumClasses-1:0] TopOnehot  = 12'h800;
  localparam logic [NumClasses-1:0] NopOnehot  = 12'h002;
  localparam logic [NumClasses-1:0] HaltOnehot = 12'h001;
  // addsub..load write a register
  localparam logic [NumClasses-1:0] WbClassMask = 12'hFF0;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StInterlock = 2'd1,
    StHalted    = 2'd2
  } state_e;

  function automatic logic [NumClasses-1:0] class_onehot(input logic [3:0] cls);
    logic [NumClasses-1:0] oh;
    if (cls < 4'(NumClasses)) begin
      oh = TopOnehot >> cls;
    end else begin
      oh = NopOnehot;
    end
    return oh;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Decode-stage register file: two async read ports, one sync write port with write-through.
// ID_R0_ZERO_EN makes R0 a constant zero.
module id_regfile #(
  parameter int unsigned WORD = 32,
  parameter int unsigned W_RD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [W_RD-1:0] waddr_i,
  input  logic [WORD-1:0] wdata_i,
  input  logic [W_RD-1:0] raddr_a_i,
  input  logic [W_RD-1:0] raddr_b_i,
  output logic [WORD-1:0] rdata_a_o,
  output logic [WORD-1:0] rdata_b_o
);

  localparam int unsigned NumRegs = 1 << W_RD;

  logic [WORD-1:0] mem_q [NumRegs];
  logic            we;

`ifdef ID_R0_ZERO_EN
  assign we = we_i && (waddr_i != '0);
`else
  assign we = we_i;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = (we && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
    rdata_b_o = (we && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
`ifdef ID_R0_ZERO_EN
    if (raddr_a_i == '0) rdata_a_o = '0;
    if (raddr_b_i == '0) rdata_b_o = '0;
`endif
  end

endmodule

// File: rtl/instr_decode.sv
// Decode stage: decodes IF instructions, reads operands and issues a registered bundle to
// execute with RAW interlock, branch squash, stall and halt. Option: ID_R0_ZERO_EN.
module instr_decode
  import id_pkg::*;
#(
  parameter int unsigned WORD   = 32,
  parameter int unsigned ADDR   = 16,
  parameter int unsigned W_RD   = 4,
  parameter int unsigned W_OPC  = 6,
  parameter int unsigned W_DOPC = 12,
  parameter int unsigned W_CC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_v_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR-1:0]   inst_addr_i,
  output logic              ready_o,
  input  logic              branch_i,
  output logic              v_o,
  input  logic              stall_i,
  output logic [WORD-1:0]   src_o,
  output logic [WORD-1:0]   dest_o,
  output logic              wb_o,
  output logic [W_RD-1:0]   rd_num_o,
  output logic [W_DOPC-1:0] dopc_o,
  output logic [W_OPC-1:0]  opc_o,
  output logic [ADDR-1:0]   origaddr_o,
  output logic [W_CC-1:0]   cc_o,
  input  logic              ex_wb_i,
  input  logic [W_RD-1:0]   ex_rd_num_i,
  input  logic [WORD-1:0]   ex_rd_data_i
);

  logic [W_OPC-1:0]  opc;
  logic [W_RD-1:0]   rd, rs;
  logic [W_CC-1:0]   cc;
  logic              imm_f;
  logic [WORD-1:0]   imm_sext, rs_data, rd_data;
  logic [3:0]        cls;
  logic [W_DOPC-1:0] dopc;
  logic              is_halt, hazard, r0_skip, ready, accept;

  state_e state_q, state_d;

  logic              v_q, v_d, wb_q;
  logic [WORD-1:0]   src_q, dest_q;
  logic [W_RD-1:0]   rd_num_q;
  logic [W_DOPC-1:0] dopc_q;
  logic [W_OPC-1:0]  opc_q;
  logic [ADDR-1:0]   origaddr_q;
  logic [W_CC-1:0]   cc_q;

  assign opc      = inst_i[OpcHi:OpcLo];
  assign rd       = inst_i[RdHi:RdLo];
  assign rs       = inst_i[RsHi:RsLo];
  assign cc       = inst_i[CcHi:CcLo];
  assign imm_f    = inst_i[ImmFlagBit];
  assign imm_sext = {{(WORD - ImmW){inst_i[ImmHi]}}, inst_i[ImmHi:0]};
  assign cls      = opc[W_OPC-1 -: 4];
  assign dopc     = class_onehot(cls);
  assign is_halt  = (dopc == HaltOnehot);

  id_regfile #(
    .WORD (WORD),
    .W_RD (W_RD)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (ex_wb_i),
    .waddr_i   (ex_rd_num_i),
    .wdata_i   (ex_rd_data_i),
    .raddr_a_i (rs),
    .raddr_b_i (rd),
    .rdata_a_o (rs_data),
    .rdata_b_o (rd_data)
  );

`ifdef ID_R0_ZERO_EN
  assign r0_skip = (rd_num_q == '0);
`else
  assign r0_skip = 1'b0;
`endif

  // Bundle in flight will write a register this instruction reads (or overwrites).
  assign hazard = (state_q == StRun) && inst_v_i && v_q && wb_q && !r0_skip &&
                  ((rd_num_q == rd) || (!imm_f && (rd_num_q == rs)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!stall_i) begin
      unique case (state_q)
        StRun, StInterlock: begin
          if (accept && is_halt) begin
            state_d = StHalted;
          end else if (hazard && !branch_i) begin
            state_d = StInterlock;
          end else begin
            state_d = StRun;
          end
        end
        StHalted: state_d = StHalted;
        default:  state_d = StRun;
      endcase
    end
  end

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      StRun:       ready = branch_i || !hazard;
      StInterlock: ready = 1'b1;
      default:     ready = 1'b0;
    endcase
    if (!rst || stall_i) begin
      ready = 1'b0;
    end
  end

  // A branch consumes the handshake but issues nothing.
  assign accept = ready && inst_v_i && !branch_i;
  assign v_d    = stall_i ? v_q : accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q        <= 1'b0;
      wb_q       <= 1'b0;
      src_q      <= '0;
      dest_q     <= '0;
      rd_num_q   <= '0;
      dopc_q     <= '0;
      opc_q      <= '0;
      origaddr_q <= '0;
      cc_q       <= '0;
    end else begin
      v_q <= v_d;
      if (accept) begin
        wb_q       <= |(dopc & WbClassMask);
        src_q      <= imm_f ? imm_sext : rs_data;
        dest_q     <= rd_data;
        rd_num_q   <= rd;
        dopc_q     <= dopc;
        opc_q      <= opc;
        origaddr_q <= inst_addr_i;
        cc_q       <= cc;
      end
    end
  end

  assign ready_o    = ready;
  assign v_o        = v_q;
  assign wb_o       = wb_q;
  assign src_o      = src_q;
  assign dest_o     = dest_q;
  assign rd_num_o   = rd_num_q;
  assign dopc_o     = dopc_q;
  assign opc_o      = opc_q;
  assign origaddr_o = origaddr_q;
  assign cc_o       = cc_q;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed scenarios plus random traffic against a
// behavioural model of the decode rules.
module tb_instr_decode;

`ifdef ID_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_v, branch, stall, ex_wb;
  logic [31:0] inst, ex_data;
  logic [15:0] inst_addr;
  logic [3:0]  ex_rd;
  logic        ready_o, v_o, wb_o;
  logic [31:0] src_o, dest_o;
  logic [3:0]  rd_num_o, cc_o;
  logic [11:0] dopc_o;
  logic [5:0]  opc_o;
  logic [15:0] origaddr_o;

  int errors = 0;
  int checks = 0;
  logic last_ready;

  // Model of the issued bundle and stage status.
  logic [31:0] m_rf [16];
  logic        m_v, m_wb, m_halted, m_bubble;
  logic [31:0] m_src, m_dest;
  logic [3:0]  m_rd, m_cc;
  logic [11:0] m_dopc;
  logic [5:0]  m_opc;
  logic [15:0] m_addr;

  always #5 clk = ~clk;

  instr_decode dut (
    .clk          (clk),
    .rst          (rst),
    .inst_v_i     (inst_v),
    .inst_i       (inst),
    .inst_addr_i  (inst_addr),
    .ready_o      (ready_o),
    .branch_i     (branch),
    .v_o          (v_o),
    .stall_i      (stall),
    .src_o        (src_o),
    .dest_o       (dest_o),
    .wb_o         (wb_o),
    .rd_num_o     (rd_num_o),
    .dopc_o       (dopc_o),
    .opc_o        (opc_o),
    .origaddr_o   (origaddr_o),
    .cc_o         (cc_o),
    .ex_wb_i      (ex_wb),
    .ex_rd_num_i  (ex_rd),
    .ex_rd_data_i (ex_data)
  );

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] cls, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [3:0] cc,
                                     input logic immf, input logic [12:0] imm);
    return {cls, 2'b00, rd, rs, cc, immf, imm};
  endfunction

  function automatic logic [31:0] rf_rd(input logic [3:0] idx);
    if (R0Z && idx == 4'd0) return 32'h0;
    if (ex_wb && ex_rd == idx) return ex_data;
    return m_rf[idx];
  endfunction

  task model_clear();
    for (int i = 0; i < 16; i++) m_rf[i] = 32'h0;
    m_v = 0; m_wb = 0; m_halted = 0; m_bubble = 0;
    m_src = 0; m_dest = 0; m_rd = 0; m_cc = 0; m_dopc = 0; m_opc = 0; m_addr = 0;
  endtask

  // One clock: inputs already driven after a negedge; returns at the next negedge.
  task step();
    logic       hz, rdy, acc, immf;
    logic [3:0] cls, rd, rs;
    logic [31:0] srcv, destv;
    #1;
    cls  = inst[31:28];
    rd   = inst[25:22];
    rs   = inst[21:18];
    immf = inst[13];
    hz   = rst && !m_halted && !m_bubble && inst_v && m_v && m_wb && !(R0Z && m_rd == 0) &&
           (m_rd == rd || (!immf && m_rd == rs));
    rdy  = rst && !stall && !m_halted && (branch || !hz);
    last_ready = ready_o;
    chk("ready_o", ready_o, rdy);
    acc   = rdy && inst_v && !branch;
    srcv  = immf ? {{19{inst[12]}}, inst[12:0]} : rf_rd(rs);
    destv = rf_rd(rd);
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else begin
      if (ex_wb && !(R0Z && ex_rd == 0)) m_rf[ex_rd] = ex_data;
      if (!stall) begin
        m_bubble = hz && !branch;
        m_v = acc;
        if (acc) begin
          m_wb   = (cls <= 4'd7);
          m_dopc = (cls < 4'd12) ? (12'h800 >> cls) : 12'h002;
          m_opc  = inst[31:26];
          m_rd   = rd;
          m_cc   = inst[17:14];
          m_addr = inst_addr;
          m_src  = srcv;
          m_dest = destv;
          if (cls == 4'd11) m_halted = 1;
        end
      end
    end
    #1;
    chk("v_o", v_o, m_v);
    chk("wb_o", wb_o, m_wb);
    chk("src_o", src_o, m_src);
    chk("dest_o", dest_o, m_dest);
    chk("rd_num_o", rd_num_o, m_rd);
    chk("dopc_o", dopc_o, m_dopc);
    chk("opc_o", opc_o, m_opc);
    chk("origaddr_o", origaddr_o, m_addr);
    chk("cc_o", cc_o, m_cc);
    @(negedge clk);
  endtask

  initial begin
    rst = 0; inst_v = 0; inst = 0; inst_addr = 0; branch = 0; stall = 0;
    ex_wb = 0; ex_rd = 0; ex_data = 0;
    model_clear();
    @(negedge clk);
    step();
    chk("reset_v", v_o, 0);
    chk("reset_ready", last_ready, 0);

    // Immediate addsub
    rst = 1;
    step();
    inst_v = 1; inst = mk(4'd0, 4'd2, 4'd0, 4'd0, 1'b1, 13'h1FFD); inst_addr = 16'h0010;
    step();
    chk("t1_v", v_o, 1);
    chk("t1_dopc", dopc_o, 32'h800);
    chk("t1_src", src_o, 32'hFFFF_FFFD);
    chk("t1_wb", wb_o, 1);
    chk("t1_rd", rd_num_o, 2);
    chk("t1_addr", origaddr_o, 16'h0010);
    inst_v = 0;
    step();

    // Write-through bypass
    ex_wb = 1; ex_rd = 4'd3; ex_data = 32'h55;
    inst_v = 1; inst = mk(4'd5, 4'd4, 4'd3, 4'd2, 1'b0, 13'h0); inst_addr = 16'h0014;
    step();
    ex_wb = 0;
    chk("t2_src", src_o, 32'h55);

    // RAW interlock
    inst = mk(4'd0, 4'd5, 4'd0, 4'd0, 1'b1, 13'd7); inst_addr = 16'h0018;
    step();
    inst = mk(4'd1, 4'd6, 4'd5, 4'd0, 1'b0, 13'h0); inst_addr = 16'h0020;
    step();
    chk("t3_ready", last_ready, 0);
    chk("t3_bubble", v_o, 0);
    ex_wb = 1; ex_rd = 4'd5; ex_data = 32'h77;
    step();
    ex_wb = 0;
    chk("t3_ready2", last_ready, 1);
    chk("t3_v", v_o, 1);
    chk("t3_src", src_o, 32'h77);
    chk("t3_addr", origaddr_o, 16'h0020);

    // Branch squash
    branch = 1; inst = mk(4'd6, 4'd7, 4'd0, 4'd0, 1'b1, 13'd1); inst_addr = 16'h0030;
    step();
    chk("t4_squash", v_o, 0);
    chk("t4_ready", last_ready, 1);
    branch = 0; inst = mk(4'd8, 4'd1, 4'd0, 4'd0, 1'b1, 13'd2); inst_addr = 16'h0034;
    step();
    chk("t4_v", v_o, 1);
    chk("t4_addr", origaddr_o, 16'h0034);

    // R0 behaviour
    inst_v = 0; ex_wb = 1; ex_rd = 4'd0; ex_data = 32'h1234;
    step();
    ex_wb = 0;
    inst_v = 1; inst = mk(4'd5, 4'd8, 4'd0, 4'd0, 1'b0, 13'h0); inst_addr = 16'h0038;
    step();
    chk("t6_r0", src_o, R0Z ? 32'h0 : 32'h1234);

    // Random traffic, halt excluded
    for (int n = 0; n < 400; n++) begin
      inst = $urandom();
      inst[25:22] = 4'($urandom_range(0, 3));
      inst[21:18] = 4'($urandom_range(0, 3));
      if (inst[31:28] == 4'd11) inst[31:28] = 4'd10;
      inst_addr = 16'($urandom());
      inst_v  = ($urandom_range(0, 9) < 8);
      branch  = ($urandom_range(0, 9) < 2);
      stall   = ($urandom_range(0, 99) < 15);
      ex_wb   = ($urandom_range(0, 9) < 3);
      ex_rd   = 4'($urandom_range(0, 3));
      ex_data = $urandom();
      step();
    end
    inst_v = 0; branch = 0; stall = 0; ex_wb = 0;
    step();
    step();

    // Halt, then sticky stall, then reset
    inst_v = 1; inst = mk(4'd11, 4'd0, 4'd0, 4'd0, 1'b1, 13'h0); inst_addr = 16'h0040;
    step();
    chk("t5_halt_v", v_o, 1);
    chk("t5_halt_dopc", dopc_o, 32'h001);
    inst = mk(4'd0, 4'd9, 4'd0, 4'd0, 1'b1, 13'd4); inst_addr = 16'h0044;
    step();
    chk("t5_after_v", v_o, 0);
    stall = 1;
    for (int n = 0; n < 5; n++) step();
    chk("t5_stall_v", v_o, 0);
    chk("t5_stall_ready", last_ready, 0);
    rst = 0; stall = 0;
    step();
    chk("t5_rst_v", v_o, 0);
    chk("t5_rst_dopc", dopc_o, 0);
    chk("t5_rst_addr", origaddr_o, 0);
    rst = 1; inst_addr = 16'h0050;
    step();
    chk("t5_run_v", v_o, 1);
    chk("t5_run_addr", origaddr_o, 16'h0050);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Decode stage sitting between fetch (IF) and the execute stage.
- Accepts 32-bit instructions from IF and decodes them to a one-hot class vector (dopc) plus a raw opcode.
- Reads operands from an internal register file that the execute stage writes back into.
- Presents a registered operand bundle to execute with valid/stall handshake, RAW interlock, branch squash and halt.

Parameters:
- WORD, 32, data width.
- ADDR, 16, instruction address width.
- W_RD, 4, register index width (2^W_RD registers).
- W_OPC, 6, raw opcode width.
- W_DOPC, 12, one-hot class width.
- W_CC, 4, condition-code field width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- inst_v_i  in  1  IF instruction valid.
- inst_i  in  32  instruction word.
- inst_addr_i  in  ADDR  instruction address.
- ready_o  out  1  stage accepts inst_i this cycle.
- branch_i  in  1  execute redirect (combinational from execute).
- v_o  out  1  bundle valid.
- stall_i  in  1  execute stall (sticky after halt).
- src_o  out  WORD  source operand.
- dest_o  out  WORD  destination-register operand.
- wb_o  out  1  instruction writes a register.
- rd_num_o  out  W_RD  destination index.
- dopc_o  out  W_DOPC  one-hot class.
- opc_o  out  W_OPC  raw opcode.
- origaddr_o  out  ADDR  instruction address.
- cc_o  out  W_CC  condition code.
- ex_wb_i  in  1  register-file write enable from execute.
- ex_rd_num_i  in  W_RD  write index.
- ex_rd_data_i  in  WORD  write data.

Behaviour:
- Instruction format:
  - opc = [31:26]
  - rd = [25:22]
  - rs = [21:18]
  - cc = [17:14]
  - imm flag = [13]
  - imm = [12:0], sign-extended to WORD
- Class decode: class = opc[5:2]. Index 0..11 maps to dopc bit W_DOPC-1-index, in this order: addsub, mul, div, abs, shift, logic, set, load, store, jump, nop, halt. Class 12..15 decodes as nop.
- wb = 1 for addsub..load; 0 for store, jump, nop, halt.
- Operands:
  - src = imm flag ? sext(imm) : R[rs].
  - dest = R[rd].
  - A same-cycle ex_wb_i write to a read index is bypassed (write-through).
- Output timing:
  - All outputs except ready_o are registered; latency is 1 cycle from acceptance.
  - Reset value of every registered output is 0.
  - ready_o is 0 during reset.
- FSM states:
  - RUN: accept when inst_v_i & ready_o.
  - INTERLOCK: one bubble inserted.
  - HALTED: terminal until reset.
- RAW interlock:
  - Trigger: in RUN, the output register holds v_o=1 & wb_o=1, and rd_num_o equals the incoming rd or (non-imm) rs.
  - Action: ready_o=0 for that cycle, the next bundle has v_o=0, and the FSM enters INTERLOCK.
  - The same instruction is accepted in the following cycle, reading the value written back by execute. INTERLOCK then returns to RUN.
- Branch:
  - When branch_i=1, the instruction presented that cycle is squashed: the next v_o=0 and its handshake is consumed (ready_o=1).
  - An interlock pending in the same cycle is cancelled.
- Stall: while stall_i=1, all output registers hold, ready_o=0, and the register file still accepts writes.
- Halt: after a halt is emitted (v_o=1 with the halt class), the FSM enters HALTED. In HALTED, ready_o=0 and v_o=0 from the next cycle on.
- Simultaneous events:
  - Priority: reset > stall_i > branch_i > interlock.
  - ex_wb_i is never blocked by stall_i.
- Reset mid-operation: the FSM returns to RUN and all registers (including the register file) clear to 0.

Optional Feature:
- Macro: ID_R0_ZERO_EN.
- Defined: R[0] reads as 0, writes to index 0 are ignored, and index 0 never triggers an interlock.
- Undefined: R0 is an ordinary register.

Decomposition:
- Package id_pkg holds:
  - field bit positions
  - class indices and the one-hot order
  - the wb-class mask
  - FSM state encoding
- Sub-module id_regfile:
  - 2^W_RD x WORD.
  - Two async read ports, one sync write port, with write-through bypass.
  - Async active-low clear.
  - Honours ID_R0_ZERO_EN.

Test Plan:
- Reset, then issue addsub rd=2, imm=1, imm=-3 at 0x0010 → next cycle: v_o=1, dopc_o=12'h800, src_o=0xFFFFFFFD, wb_o=1, rd_num_o=2, origaddr_o=0x0010.
- Execute writes R3=0x55 (ex_wb_i) in the same cycle a logic rs=3 (non-imm) instruction is accepted → src_o=0x55 via bypass.
- Back-to-back instructions, the first writing R5 and the second reading rs=5 → ready_o=0 for one cycle, one v_o=0 bubble, second instruction issued the cycle after.
- branch_i=1 while the following instruction is presented → next v_o=0; the instruction after that issues normally with its own origaddr_o.
- Halt issued, then stall_i held high → outputs frozen, ready_o=0; after 5 cycles still v_o=0 and no new acceptance; assert rst → all outputs 0 and the FSM is in RUN.
- With ID_R0_ZERO_EN: write R0=0x1234, then read rs=0 → src_o=0; without the macro → src_o=0x1234.
